mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 bit-mux between four requesters. It grants the mux to one requester at a time, drives the 2-bit select, and presents the selected data bit. A configurable hold limit bounds how long one owner keeps the mux while others wait. It sits in the top-level wrapper between the ui_in request/data pins and uo_out[0].

---
 rtl/mux4_arb_pkg.sv | 28 ++
 rtl/mux4_rr_arbiter_pick.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types, widths and helpers for the 4-requester round-robin mux arbiter.
// Contents: state enum (IDLE/GRANT), NUM_REQ/SEL_W widths, one-hot <-> index helpers.
package mux4_arb_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Index to one-hot grant vector.
   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

   // One-hot vector to index; lowest set bit wins, zero maps to 0.
   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (oh[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Round-robin pick: first asserted request at or after (last+1) mod 4, with
// wrap-around. exclude_en removes requester 'last' from the search (rotation).
// Ports: req[3:0], last[1:0], exclude_en in; pick[1:0], any out. Purely combinational.
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last,
   input  logic               exclude_en,
   output logic [SEL_W-1:0]   pick,
   output logic               any
);

   logic [SEL_W-1:0] idx;

   // Walk offsets 1..4 from last; the 2-bit add wraps naturally.
   always_comb begin
      pick = '0;
      any  = 1'b0;
      idx  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = last + SEL_W'(k);
         if (!any && req[idx] && !(exclude_en && (idx == last))) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit-mux between four requesters, with a
// hold limit of MAX_HOLD cycles while others wait.
// Ports: clk, rst_n (sync, active-low), ena (freeze when low), req[3:0],
//        data_in[3:0]; gnt[3:0], sel[1:0], valid, hold_cnt registered;
//        data_out combinational from registered sel/valid.
// Optional: define MUX4_ARB_LOCK_EN to add input 'lock' that suppresses
//           hold-limit rotation while the owner keeps requesting.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned HOLD_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
`ifdef MUX4_ARB_LOCK_EN
   input  logic               lock,
`endif
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] data_in,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic               valid,
   output logic               data_out,
   output logic [HOLD_W-1:0]  hold_cnt
);

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   last_q, last_d;
   logic               valid_q, valid_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;

   logic [SEL_W-1:0]   pick_idx;
   logic               pick_any;
   logic               owner_req;
   logic               rotate_ok;

   assign owner_req = req[sel_q];

`ifdef MUX4_ARB_LOCK_EN
   assign rotate_ok = !(valid_q && lock);
`else
   assign rotate_ok = 1'b1;
`endif

   // While the owner still requests, exclude it so 'any' means "someone else waits".
   rr_pick4 u_pick (
      .req        (req),
      .last       (last_q),
      .exclude_en ((state_q == GRANT) && owner_req),
      .pick       (pick_idx),
      .any        (pick_any)
   );

   // State register and datapath flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= SEL_W'(NUM_REQ - 1);
         valid_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (ena) begin
         case (state_q)
            IDLE:    if (pick_any) state_d = GRANT;
            GRANT:   if (!owner_req && !pick_any) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Grant, select, pointer and hold-counter updates.
   always_comb begin
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      valid_d = valid_q;
      hold_d  = hold_q;
      if (ena) begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  gnt_d   = idx_to_onehot(pick_idx);
                  sel_d   = pick_idx;
                  last_d  = pick_idx;
                  valid_d = 1'b1;
                  hold_d  = '0;
               end
            end
            GRANT: begin
               if (!owner_req) begin
                  // Release: hand over directly, or drop to idle keeping sel.
                  if (pick_any) begin
                     gnt_d   = idx_to_onehot(pick_idx);
                     sel_d   = pick_idx;
                     last_d  = pick_idx;
                     valid_d = 1'b1;
                  end else begin
                     gnt_d   = '0;
                     valid_d = 1'b0;
                  end
                  hold_d = '0;
               end else if ((hold_q == HOLD_MAX) && pick_any && rotate_ok) begin
                  gnt_d   = idx_to_onehot(pick_idx);
                  sel_d   = pick_idx;
                  last_d  = pick_idx;
                  valid_d = 1'b1;
                  hold_d  = '0;
               end else if (hold_q != HOLD_MAX) begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
            default: begin
               gnt_d   = '0;
               valid_d = 1'b0;
               hold_d  = '0;
            end
         endcase
      end
   end

   assign gnt      = gnt_q;
   assign sel      = sel_q;
   assign valid    = valid_q;
   assign hold_cnt = hold_q;
   assign data_out = valid_q & data_in[sel_q];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=1) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_mux4_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n, ena;
   logic [3:0] req, data_in;

   logic [3:0] gnt4, gnt1;
   logic [1:0] sel4, sel1;
   logic       valid4, valid1, dout4, dout1;
   logic [7:0] hc4, hc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .data_in(data_in),
      .gnt(gnt4), .sel(sel4), .valid(valid4), .data_out(dout4), .hold_cnt(hc4)
   );

   mux4_rr_arbiter #(.MAX_HOLD(1), .HOLD_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .data_in(data_in),
      .gnt(gnt1), .sel(sel1), .valid(valid1), .data_out(dout1), .hold_cnt(hc1)
   );

   // Model state per instance: owner (-1 = none), round-robin pointer, held cycles.
   int m_max[2]   = '{4, 1};
   int m_owner[2];
   int m_last[2];
   int m_sel[2];
   int m_cnt[2];
   bit m_cnt_known[2];

   // First requester after 'from' in circular order, skipping 'skip'; -1 if none.
   function automatic int rr_next(int from, logic [3:0] r, int skip);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (from + k) % 4;
         if (r[i] && i != skip) return i;
      end
      return -1;
   endfunction

   task automatic model_grant(int m, int p);
      m_owner[m] = p;
      m_sel[m] = p;
      m_last[m] = p;
      m_cnt[m] = 0;
      m_cnt_known[m] = 1'b1;
   endtask

   task automatic model_step(int m);
      int p;
      if (!rst_n) begin
         m_owner[m] = -1; m_sel[m] = 0; m_last[m] = 3; m_cnt[m] = 0; m_cnt_known[m] = 1'b1;
      end else if (ena) begin
         if (m_owner[m] < 0) begin
            p = rr_next(m_last[m], req, -1);
            if (p >= 0) model_grant(m, p);
         end else if (!req[m_owner[m]]) begin
            p = rr_next(m_owner[m], req, m_owner[m]);
            if (p >= 0) model_grant(m, p);
            else begin
               m_owner[m] = -1;
               m_cnt_known[m] = 1'b0;
            end
         end else begin
            p = rr_next(m_owner[m], req, m_owner[m]);
            if (m_cnt[m] >= m_max[m] - 1 && p >= 0) model_grant(m, p);
            else if (m_cnt[m] < m_max[m] - 1) m_cnt[m] = m_cnt[m] + 1;
         end
      end
   endtask

   task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic [3:0] eg;
      logic [7:0] og [2];
      logic [7:0] os [2];
      logic [7:0] ov [2];
      logic [7:0] od [2];
      logic [7:0] oh [2];
      og[0] = 8'(gnt4); os[0] = 8'(sel4); ov[0] = 8'(valid4); od[0] = 8'(dout4); oh[0] = hc4;
      og[1] = 8'(gnt1); os[1] = 8'(sel1); ov[1] = 8'(valid1); od[1] = 8'(dout1); oh[1] = hc1;
      for (int m = 0; m < 2; m++) begin
         eg = (m_owner[m] >= 0) ? 4'(1 << m_owner[m]) : 4'b0000;
         chk(m == 0 ? "gnt_h4" : "gnt_h1", og[m], 8'(eg));
         chk(m == 0 ? "sel_h4" : "sel_h1", os[m], 8'(m_sel[m]));
         chk(m == 0 ? "valid_h4" : "valid_h1", ov[m], 8'(m_owner[m] >= 0));
         chk(m == 0 ? "dout_h4" : "dout_h1", od[m],
             8'((m_owner[m] >= 0) ? data_in[m_sel[m]] : 1'b0));
         if (m_cnt_known[m]) chk(m == 0 ? "hold_h4" : "hold_h1", oh[m], 8'(m_cnt[m]));
      end
   endtask

   // One clock: model samples the same inputs the DUT sees, outputs compared 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_all();
      data_in = 4'($urandom);
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; req = 4'b0000; data_in = 4'($urandom);
      m_owner = '{-1, -1}; m_last = '{3, 3}; m_sel = '{0, 0}; m_cnt = '{0, 0};
      m_cnt_known = '{1'b1, 1'b1};
      cycle();
      cycle();
      rst_n = 1'b1;

      // Single requester, then release.
      req = 4'b0001;
      cycle();
      chk("first_gnt", 8'(gnt4), 8'h01);
      chk("first_valid", 8'(valid4), 8'h01);
      cycle();
      req = 4'b0000;
      cycle();
      chk("release_gnt", 8'(gnt4), 8'h00);

      // Two steady requesters: hold-limit rotation.
      req = 4'b0011;
      repeat (18) cycle();

      // Owner 2 releases while 0 and 3 request: direct hand-over to 3.
      req = 4'b0000;
      cycle();
      req = 4'b0100;
      cycle();
      chk("own2_sel", 8'(sel4), 8'h02);
      cycle();
      req = 4'b1001;
      cycle();
      chk("handover_sel", 8'(sel4), 8'h03);
      chk("handover_gnt", 8'(gnt4), 8'h08);
      chk("handover_valid", 8'(valid4), 8'h01);

      // All requesting: MAX_HOLD=1 instance rotates every cycle.
      req = 4'b1111;
      repeat (10) cycle();

      // Freeze mid-grant.
      req = 4'b0110;
      repeat (2) cycle();
      ena = 1'b0;
      repeat (3) cycle();
      ena = 1'b1;
      repeat (5) cycle();

      // Reset during a grant of owner 1.
      req = 4'b0010;
      repeat (2) cycle();
      chk("pre_rst_sel", 8'(sel4), 8'h01);
      rst_n = 1'b0;
      cycle();
      chk("rst_gnt", 8'(gnt4), 8'h00);
      chk("rst_sel", 8'(sel4), 8'h00);
      chk("rst_valid", 8'(valid4), 8'h00);
      rst_n = 1'b1;
      cycle();
      chk("post_rst_sel", 8'(sel4), 8'h01);

      // Randomised traffic: requests change occasionally so holds develop.
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         ena   = ($urandom_range(0, 7) != 0);
         rst_n = ($urandom_range(0, 99) != 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
